// File: rtl/regfile_operand_stage_if.sv
// Decode/write-back to execute bundle for regfile_operand_stage.
// Master drives requests and write-back; slave returns registered operands.
interface regfile_operand_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              in_valid;
  logic              stall;
  logic [ADDR_W-1:0] Read_register1;
  logic [ADDR_W-1:0] Read_register2;
  logic              Issue_valid;
  logic [ADDR_W-1:0] Issue_dest;
  logic              RegWrite;
  logic              MemtoReg;
  logic [ADDR_W-1:0] Write_register;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] ALU_Result;
  logic [DATA_W-1:0] Read_data1;
  logic [DATA_W-1:0] Read_data2;
  logic              out_valid;
  logic              hazard;

  modport master (
    output in_valid, stall, Read_register1, Read_register2, Issue_valid, Issue_dest,
    output RegWrite, MemtoReg, Write_register, data, ALU_Result,
    input  Read_data1, Read_data2, out_valid, hazard
  );

  modport slave (
    input  in_valid, stall, Read_register1, Read_register2, Issue_valid, Issue_dest,
    input  RegWrite, MemtoReg, Write_register, data, ALU_Result,
    output Read_data1, Read_data2, out_valid, hazard
  );
endinterface

// File: rtl/regfile_operand_stage.sv
// Register file with write-back mux, same-cycle bypass, pending-write scoreboard
// and a single registered operand entry feeding execute.
module regfile_operand_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_operand_stage_if.slave bus
);
  localparam int unsigned NREGS  = 2 ** ADDR_W;
  localparam logic        ZeroEn = (ZERO_REG != 0);
  localparam logic        ByEn   = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  pending_q, pending_d;
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic              out_valid_q, out_valid_d;

  logic [DATA_W-1:0] wv, op1, op2;
  logic              we, hit1, hit2, zero1, zero2, p1, p2, hazard, issue_set;

  always_comb begin
    wv    = bus.MemtoReg ? bus.data : bus.ALU_Result;
    we    = bus.RegWrite && !(ZeroEn && (bus.Write_register == '0));
    hit1  = we && (bus.Write_register == bus.Read_register1);
    hit2  = we && (bus.Write_register == bus.Read_register2);
    zero1 = ZeroEn && (bus.Read_register1 == '0);
    zero2 = ZeroEn && (bus.Read_register2 == '0);

    if (zero1)             op1 = '0;
    else if (ByEn && hit1) op1 = wv;
    else                   op1 = regs_q[bus.Read_register1];

    if (zero2)             op2 = '0;
    else if (ByEn && hit2) op2 = wv;
    else                   op2 = regs_q[bus.Read_register2];

    // Without bypass a retiring producer cannot be forwarded, so it still blocks.
    p1 = pending_q[bus.Read_register1] && !(ByEn && hit1) && !zero1;
    p2 = pending_q[bus.Read_register2] && !(ByEn && hit2) && !zero2;
    hazard = bus.in_valid && (p1 || p2);

    issue_set = bus.Issue_valid && !bus.stall && !hazard && bus.in_valid &&
                !(ZeroEn && (bus.Issue_dest == '0));
  end

  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    if (we) begin
      regs_d[bus.Write_register]    = wv;
      pending_d[bus.Write_register] = 1'b0;
    end
    // Set after clear: a fresh producer on the retiring index stays outstanding.
    if (issue_set) pending_d[bus.Issue_dest] = 1'b1;
  end

  always_comb begin
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    out_valid_d = out_valid_q;
    if (!bus.stall) begin
      if (bus.in_valid && !hazard) begin
        rd1_d       = op1;
        rd2_d       = op2;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
      pending_q   <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      pending_q   <= pending_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.Read_data1 = rd1_q;
  assign bus.Read_data2 = rd2_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.hazard     = hazard;
endmodule

// File: tb/tb_regfile_operand_stage.sv
// Bench for regfile_operand_stage: directed vector table, random run against a
// reference model, and an asynchronous mid-cycle reset sequence.
module tb_regfile_operand_stage;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_operand_stage_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  regfile_operand_stage_if #(.DATA_W(DW), .ADDR_W(AW)) bus_nb ();

  assign bus_nb.in_valid       = bus.in_valid;
  assign bus_nb.stall          = bus.stall;
  assign bus_nb.Read_register1 = bus.Read_register1;
  assign bus_nb.Read_register2 = bus.Read_register2;
  assign bus_nb.Issue_valid    = bus.Issue_valid;
  assign bus_nb.Issue_dest     = bus.Issue_dest;
  assign bus_nb.RegWrite       = bus.RegWrite;
  assign bus_nb.MemtoReg       = bus.MemtoReg;
  assign bus_nb.Write_register = bus.Write_register;
  assign bus_nb.data           = bus.data;
  assign bus_nb.ALU_Result     = bus.ALU_Result;

  regfile_operand_stage #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  regfile_operand_stage #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_nb.slave)
  );

  typedef struct {
    logic        iv, st;
    logic [4:0]  r1, r2;
    logic        isv;
    logic [4:0]  idst;
    logic        rw, mtr;
    logic [4:0]  wr;
    logic [31:0] dat, alu;
    logic        e_hz;
    logic [31:0] e_rd1, e_rd2;
    logic        e_ov;
    logic        chk_nb;
    logic [31:0] e_nb1, e_nb2;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_mem [NR];
  logic        m_pend [NR];
  logic [31:0] m_rd1, m_rd2;
  logic        m_ov;

  vec_t vecs [26];

  function automatic vec_t mk(
    input logic iv, input logic st, input logic [4:0] r1, input logic [4:0] r2,
    input logic isv, input logic [4:0] idst, input logic rw, input logic mtr,
    input logic [4:0] wr, input logic [31:0] dat, input logic [31:0] alu,
    input logic e_hz, input logic [31:0] e1, input logic [31:0] e2, input logic e_ov);
    vec_t v;
    v.iv = iv; v.st = st; v.r1 = r1; v.r2 = r2; v.isv = isv; v.idst = idst;
    v.rw = rw; v.mtr = mtr; v.wr = wr; v.dat = dat; v.alu = alu;
    v.e_hz = e_hz; v.e_rd1 = e1; v.e_rd2 = e2; v.e_ov = e_ov;
    v.chk_nb = 1'b0; v.e_nb1 = '0; v.e_nb2 = '0;
    return v;
  endfunction

  function automatic vec_t rnd();
    vec_t v;
    v = mk(($urandom_range(0, 9) < 8), ($urandom_range(0, 4) == 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), $urandom, $urandom, 0, 0, 0, 0);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NR); i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_rd1 = '0;
    m_rd2 = '0;
    m_ov  = 1'b0;
  endtask

  // Entered shortly after a rising edge; leaves 1 time unit after the next one.
  task automatic run_cycle(input vec_t v, input bit use_tab, input string tag);
    logic [31:0] wv, op1, op2;
    logic        we, p1, p2, hz;
    bus.in_valid       = v.iv;
    bus.stall          = v.st;
    bus.Read_register1 = v.r1;
    bus.Read_register2 = v.r2;
    bus.Issue_valid    = v.isv;
    bus.Issue_dest     = v.idst;
    bus.RegWrite       = v.rw;
    bus.MemtoReg       = v.mtr;
    bus.Write_register = v.wr;
    bus.data           = v.dat;
    bus.ALU_Result     = v.alu;

    wv  = v.mtr ? v.dat : v.alu;
    we  = v.rw && (v.wr != 0);
    op1 = (v.r1 == 0) ? 32'h0 : ((we && v.wr == v.r1) ? wv : m_mem[v.r1]);
    op2 = (v.r2 == 0) ? 32'h0 : ((we && v.wr == v.r2) ? wv : m_mem[v.r2]);
    p1  = m_pend[v.r1] && !(we && v.wr == v.r1) && (v.r1 != 0);
    p2  = m_pend[v.r2] && !(we && v.wr == v.r2) && (v.r2 != 0);
    hz  = v.iv && (p1 || p2);

    #3;
    check($sformatf("%s hazard", tag), 32'(bus.hazard), use_tab ? 32'(v.e_hz) : 32'(hz));
    @(posedge clk);
    #1;

    if (we) begin
      m_mem[v.wr]  = wv;
      m_pend[v.wr] = 1'b0;
    end
    if (v.isv && !v.st && !hz && v.iv && v.idst != 0) m_pend[v.idst] = 1'b1;
    if (!v.st) begin
      if (v.iv && !hz) begin
        m_rd1 = op1;
        m_rd2 = op2;
        m_ov  = 1'b1;
      end else begin
        m_ov = 1'b0;
      end
    end

    check($sformatf("%s Read_data1", tag), bus.Read_data1, use_tab ? v.e_rd1 : m_rd1);
    check($sformatf("%s Read_data2", tag), bus.Read_data2, use_tab ? v.e_rd2 : m_rd2);
    check($sformatf("%s out_valid", tag), 32'(bus.out_valid),
          use_tab ? 32'(v.e_ov) : 32'(m_ov));
    if (v.chk_nb) begin
      check($sformatf("%s nobypass Read_data1", tag), bus_nb.Read_data1, v.e_nb1);
      check($sformatf("%s nobypass Read_data2", tag), bus_nb.Read_data2, v.e_nb2);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    bus.in_valid = 0; bus.stall = 0; bus.Read_register1 = 0; bus.Read_register2 = 0;
    bus.Issue_valid = 0; bus.Issue_dest = 0; bus.RegWrite = 0; bus.MemtoReg = 0;
    bus.Write_register = 0; bus.data = 0; bus.ALU_Result = 0;
    model_reset();

    vecs[0]  = mk(0,0,0,0,0,0,1,0,3,0,32'h1234,        0,32'h0,32'h0,0);
    vecs[1]  = mk(1,0,3,3,0,0,0,0,0,0,0,               0,32'h1234,32'h1234,1);
    vecs[2]  = mk(0,0,0,0,0,0,1,1,3,32'hDEAD0000,0,    0,32'h1234,32'h1234,0);
    vecs[3]  = mk(1,0,3,0,0,0,0,0,0,0,0,               0,32'hDEAD0000,32'h0,1);
    vecs[4]  = mk(1,0,7,7,0,0,1,0,7,0,32'hCAFE,        0,32'hCAFE,32'hCAFE,1);
    vecs[5]  = mk(1,0,7,3,0,0,0,0,0,0,0,               0,32'hCAFE,32'hDEAD0000,1);
    vecs[6]  = mk(1,0,0,0,1,0,1,0,0,0,32'hFFFFFFFF,    0,32'h0,32'h0,1);
    vecs[7]  = mk(1,0,0,0,0,0,0,0,0,0,0,               0,32'h0,32'h0,1);
    vecs[8]  = mk(1,0,3,3,1,9,0,0,0,0,0,               0,32'hDEAD0000,32'hDEAD0000,1);
    vecs[9]  = mk(1,0,9,3,0,0,0,0,0,0,0,               1,32'hDEAD0000,32'hDEAD0000,0);
    vecs[10] = mk(1,0,9,9,0,0,1,0,9,0,32'h55,          0,32'h55,32'h55,1);
    vecs[11] = mk(1,0,3,3,1,9,1,0,9,0,32'h66,          0,32'hDEAD0000,32'hDEAD0000,1);
    vecs[12] = mk(1,0,9,9,0,0,0,0,0,0,0,               1,32'hDEAD0000,32'hDEAD0000,0);
    vecs[13] = mk(0,0,0,0,0,0,1,0,9,0,32'h77,          0,32'hDEAD0000,32'hDEAD0000,0);
    vecs[14] = mk(1,0,9,1,0,0,0,0,0,0,0,               0,32'h77,32'h0,1);
    vecs[15] = mk(0,0,0,0,0,0,1,0,1,0,32'h11,          0,32'h77,32'h0,0);
    vecs[16] = mk(1,0,1,2,0,0,1,0,2,0,32'h22,          0,32'h11,32'h22,1);
    vecs[17] = mk(1,1,1,2,0,0,1,0,1,0,32'hAA,          0,32'h11,32'h22,1);
    vecs[18] = mk(1,1,1,2,0,0,1,1,2,32'hBB,0,          0,32'h11,32'h22,1);
    vecs[19] = mk(1,1,1,2,0,0,1,0,1,0,32'hCC,          0,32'h11,32'h22,1);
    vecs[20] = mk(1,0,1,2,0,0,0,0,0,0,0,               0,32'hCC,32'hBB,1);
    vecs[21] = mk(1,0,1,2,1,4,0,0,0,0,0,               0,32'hCC,32'hBB,1);
    vecs[22] = mk(1,1,4,1,0,0,0,0,0,0,0,               1,32'hCC,32'hBB,1);
    vecs[23] = mk(1,0,4,1,0,0,0,0,0,0,0,               1,32'hCC,32'hBB,0);
    vecs[24] = mk(1,1,1,2,1,5,0,0,0,0,0,               0,32'hCC,32'hBB,0);
    vecs[25] = mk(1,0,5,1,0,0,0,0,0,0,0,               0,32'h0,32'hCC,1);
    vecs[4].chk_nb = 1'b1; vecs[4].e_nb1 = 32'h0;    vecs[4].e_nb2 = 32'h0;
    vecs[5].chk_nb = 1'b1; vecs[5].e_nb1 = 32'hCAFE; vecs[5].e_nb2 = 32'hDEAD0000;

    @(posedge clk);
    #1;
    check("reset Read_data1", bus.Read_data1, 32'h0);
    check("reset Read_data2", bus.Read_data2, 32'h0);
    check("reset out_valid", 32'(bus.out_valid), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) run_cycle(vecs[i], 1'b1, $sformatf("vec%0d", i));

    for (int i = 0; i < 400; i++) begin
      v = rnd();
      run_cycle(v, 1'b0, $sformatf("rnd%0d", i));
    end

    // Preload r5, load it into the operand register, then reset mid-cycle.
    run_cycle(mk(0,0,0,0,0,0,1,0,5,0,32'hABC, 0,0,0,0), 1'b0, "pre_wr");
    run_cycle(mk(1,0,5,5,0,0,0,0,0,0,0, 0,0,0,0), 1'b0, "pre_rd");
    bus.in_valid = 1'b0; bus.stall = 1'b0; bus.Issue_valid = 1'b0;
    bus.RegWrite = 1'b1; bus.MemtoReg = 1'b0; bus.Write_register = 5'd5;
    bus.ALU_Result = 32'h999;
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset Read_data1", bus.Read_data1, 32'h0);
    check("async reset Read_data2", bus.Read_data2, 32'h0);
    check("async reset out_valid", 32'(bus.out_valid), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_cycle(mk(1,0,5,4,0,0,0,0,0,0,0, 0,32'h0,32'h0,1), 1'b1, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
